iir_mac_acc: RTL and testbench

- Sequential accumulate/requantise stage directly downstream of the 4x4 signed Baugh-Wooley multiplier in the IIR datapath.
- Consumes a stream of 8-bit signed tap products, one frame per output sample, and accumulates them with saturation.
- Rounds and saturates each frame result back to the 4-bit sample width.
- Holds the last two outputs as feedback history (y[n-1], y[n-2]) for the recursive taps.

---
 rtl/iir_pkg.sv | 31 +++
 rtl/iir_round_sat.sv | 21 ++
 rtl/iir_mac_acc.sv | 110 +++++++++++
 tb/tb_iir_mac_acc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared widths, FSM state type and signed saturation helper for the IIR requantisation datapath.
package iir_pkg;

  localparam int unsigned PROD_W    = 8;
  localparam int unsigned ACC_W     = 10;
  localparam int unsigned OUT_W     = 4;
  localparam int unsigned SHIFT     = 3;
  localparam int unsigned MAX_TAPS  = 8;
  localparam int unsigned SUM_W     = ACC_W + 1;
  localparam int unsigned TAP_CNT_W = $clog2(MAX_TAPS);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Clamp a SUM_W-bit signed value into the signed range of a w-bit word (w <= SUM_W).
  function automatic logic signed [SUM_W-1:0] sat_signed(input logic signed [SUM_W-1:0] x,
                                                        input int unsigned w);
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    logic signed [SUM_W-1:0] res;
    hi = $signed(SUM_W'((64'd1 << (w - 1)) - 64'd1));
    lo = ~hi;
    res = x;
    if (x > hi) res = hi;
    else if (x < lo) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Combinational requantiser: add half an LSB, arithmetic shift right, saturate to OUT_W.
module iir_round_sat
  import iir_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_val,
  output logic signed [OUT_W-1:0] y_c
);

  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1 << (SHIFT - 1));

  logic signed [SUM_W-1:0] biased;
  logic signed [SUM_W-1:0] shifted;

  // Extra headroom bit keeps the rounding add from wrapping at +max.
  always_comb begin
    biased  = {acc_val[ACC_W-1], acc_val} + HALF;
    shifted = biased >>> SHIFT;
    y_c     = OUT_W'(sat_signed(shifted, OUT_W));
  end

endmodule

// File: rtl/iir_mac_acc.sv
// Saturating accumulate of a frame of tap products, requantised to one output sample with feedback history.
module iir_mac_acc
  import iir_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [PROD_W-1:0]    prod_i,
  input  logic                        prod_valid_i,
  input  logic                        prod_last_i,
  output logic                        prod_ready_o,
  output logic signed [OUT_W-1:0]     y_o,
  output logic                        y_valid_o,
  input  logic                        y_ready_i,
  output logic signed [OUT_W-1:0]     y_d1_o,
  output logic signed [OUT_W-1:0]     y_d2_o,
  output logic                        ovf_o,
  input  logic                        clr_ovf_i,
  output logic                        err_taps_o,
  output logic [TAP_CNT_W-1:0]        tap_cnt_o
);

  state_t                    state, state_d;
  logic signed [ACC_W-1:0]   acc, acc_d;
  logic [TAP_CNT_W-1:0]      tap_cnt_d;
  logic signed [OUT_W-1:0]   y_d, y_d1_d, y_d2_d, y_round_c;
  logic                      y_valid_d, ovf_d, err_taps_d;

  logic                      beat;
  logic                      at_max;
  logic signed [SUM_W-1:0]   sum;
  logic signed [ACC_W-1:0]   sum_clamped;
  logic                      sum_ovf;

  assign prod_ready_o = (state == ACC);
  assign beat         = prod_valid_i & prod_ready_o;
  assign at_max       = (tap_cnt_o == TAP_CNT_W'(MAX_TAPS - 1));

  // Two sign bits of the widened sum disagree exactly when ACC_W would overflow.
  assign sum         = {acc[ACC_W-1], acc} + {{(SUM_W - PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign sum_ovf     = sum[SUM_W-1] ^ sum[SUM_W-2];
  assign sum_clamped = ACC_W'(sat_signed(sum, ACC_W));

  iir_round_sat u_round_sat (
    .acc_val (sum_clamped),
    .y_c     (y_round_c)
  );

  always_comb begin
    state_d    = state;
    acc_d      = acc;
    tap_cnt_d  = tap_cnt_o;
    y_d        = y_o;
    y_valid_d  = y_valid_o;
    y_d1_d     = y_d1_o;
    y_d2_d     = y_d2_o;
    err_taps_d = 1'b0;
    ovf_d      = ovf_o & ~clr_ovf_i;
    case (state)
      ACC: begin
        if (beat) begin
          acc_d     = sum_clamped;
          tap_cnt_d = tap_cnt_o + TAP_CNT_W'(1);
          if (sum_ovf) ovf_d = 1'b1;
          if (prod_last_i || at_max) begin
            y_d        = y_round_c;
            y_valid_d  = 1'b1;
            acc_d      = '0;
            tap_cnt_d  = '0;
            err_taps_d = ~prod_last_i;
            state_d    = OUT;
          end
        end
      end
      OUT: begin
        if (y_ready_i) begin
          y_d2_d    = y_d1_o;
          y_d1_d    = y_o;
          y_valid_d = 1'b0;
          state_d   = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACC;
      acc        <= '0;
      tap_cnt_o  <= '0;
      y_o        <= '0;
      y_valid_o  <= 1'b0;
      y_d1_o     <= '0;
      y_d2_o     <= '0;
      ovf_o      <= 1'b0;
      err_taps_o <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      tap_cnt_o  <= tap_cnt_d;
      y_o        <= y_d;
      y_valid_o  <= y_valid_d;
      y_d1_o     <= y_d1_d;
      y_d2_o     <= y_d2_d;
      ovf_o      <= ovf_d;
      err_taps_o <= err_taps_d;
    end
  end

endmodule

// File: tb/tb_iir_mac_acc.sv
// Self-checking bench for iir_mac_acc: directed table, corner sequences and random frames vs a reference model.
module tb_iir_mac_acc;
  import iir_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [PROD_W-1:0] prod_i;
  logic                     prod_valid_i, prod_last_i, prod_ready_o;
  logic signed [OUT_W-1:0]  y_o, y_d1_o, y_d2_o;
  logic                     y_valid_o, y_ready_i, ovf_o, clr_ovf_i, err_taps_o;
  logic [TAP_CNT_W-1:0]     tap_cnt_o;

  iir_mac_acc dut (
    .clk          (clk),
    .rst          (rst),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .prod_last_i  (prod_last_i),
    .prod_ready_o (prod_ready_o),
    .y_o          (y_o),
    .y_valid_o    (y_valid_o),
    .y_ready_i    (y_ready_i),
    .y_d1_o       (y_d1_o),
    .y_d2_o       (y_d2_o),
    .ovf_o        (ovf_o),
    .clr_ovf_i    (clr_ovf_i),
    .err_taps_o   (err_taps_o),
    .tap_cnt_o    (tap_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int model_d1 = 0;
  int model_d2 = 0;
  int model_ovf = 0;
  int exp_y_cur = 0;
  int fq[$];

  typedef struct {
    int n;
    int p[8];
    int exp_y;
    int exp_ovf;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: clamp running sum to ACC_W range, round half-up, floor-divide, clamp to OUT_W range.
  function automatic int model_frame(output int hit);
    int acc;
    int v;
    int q;
    acc = 0;
    hit = 0;
    foreach (fq[i]) begin
      acc += fq[i];
      if (acc > 511) begin acc = 511; hit = 1; end
      else if (acc < -512) begin acc = -512; hit = 1; end
    end
    v = acc + 4;
    q = v / 8;
    if (v < 0 && (v % 8) != 0) q--;
    if (q > 7) q = 7;
    if (q < -8) q = -8;
    return q;
  endfunction

  task automatic send_frame(input bit with_last, input int gap_max);
    int budget;
    int g;
    for (int i = 0; i < fq.size(); i++) begin
      g = $urandom_range(gap_max, 0);
      repeat (g) begin
        prod_valid_i = 1'b0;
        prod_i       = PROD_W'($urandom);
        prod_last_i  = 1'($urandom);
        step();
      end
      prod_valid_i = 1'b1;
      prod_i       = PROD_W'(fq[i]);
      prod_last_i  = with_last && (i == fq.size() - 1);
      budget = 0;
      while (!prod_ready_o && budget < 20) begin
        step();
        budget++;
      end
      if (!prod_ready_o) check("ready_timeout", 0, 1);
      step();
    end
    prod_valid_i = 1'b0;
    prod_last_i  = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int exp_y, input int exp_ovf, input int exp_err);
    exp_y_cur = exp_y;
    check({tag, "_y_valid"}, int'(y_valid_o), 1);
    check({tag, "_y"}, int'(y_o), exp_y);
    check({tag, "_ovf"}, int'(ovf_o), exp_ovf);
    check({tag, "_err"}, int'(err_taps_o), exp_err);
    check({tag, "_tap_cnt"}, int'(tap_cnt_o), 0);
    check({tag, "_ready_low"}, int'(prod_ready_o), 0);
  endtask

  task automatic accept(input int hold);
    repeat (hold) begin
      y_ready_i = 1'b0;
      step();
      check("hold_y_stable", int'(y_o), exp_y_cur);
      check("hold_valid", int'(y_valid_o), 1);
      check("hold_ready_low", int'(prod_ready_o), 0);
      check("hold_err_clear", int'(err_taps_o), 0);
    end
    y_ready_i = 1'b1;
    step();
    y_ready_i = 1'b0;
    model_d2 = model_d1;
    model_d1 = exp_y_cur;
    check("acc_y_d1", int'(y_d1_o), model_d1);
    check("acc_y_d2", int'(y_d2_o), model_d2);
    check("acc_valid_low", int'(y_valid_o), 0);
    check("acc_ready_high", int'(prod_ready_o), 1);
    check("acc_err_clear", int'(err_taps_o), 0);
  endtask

  task automatic pulse_clr_ovf();
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    model_ovf = 0;
    check("clr_ovf", int'(ovf_o), 0);
  endtask

  initial begin
    int hit;
    int ey;
    int len;
    bit wl;

    tbl[0] = '{n: 2, p: '{20, -4, 0, 0, 0, 0, 0, 0}, exp_y: 2, exp_ovf: 0};
    tbl[1] = '{n: 3, p: '{127, 127, 127, 0, 0, 0, 0, 0}, exp_y: 7, exp_ovf: 0};
    tbl[2] = '{n: 1, p: '{-4, 0, 0, 0, 0, 0, 0, 0}, exp_y: 0, exp_ovf: 0};
    tbl[3] = '{n: 1, p: '{-5, 0, 0, 0, 0, 0, 0, 0}, exp_y: -1, exp_ovf: 0};
    tbl[4] = '{n: 5, p: '{127, 127, 127, 127, 127, 0, 0, 0}, exp_y: 7, exp_ovf: 1};

    rst = 1'b1; prod_i = '0; prod_valid_i = 1'b0; prod_last_i = 1'b0;
    y_ready_i = 1'b0; clr_ovf_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_y", int'(y_o), 0);
    check("rst_y_valid", int'(y_valid_o), 0);
    check("rst_y_d1", int'(y_d1_o), 0);
    check("rst_y_d2", int'(y_d2_o), 0);
    check("rst_ovf", int'(ovf_o), 0);
    check("rst_err", int'(err_taps_o), 0);
    check("rst_tap_cnt", int'(tap_cnt_o), 0);
    check("rst_ready", int'(prod_ready_o), 1);

    for (int t = 0; t < 5; t++) begin
      fq.delete();
      for (int j = 0; j < tbl[t].n; j++) fq.push_back(tbl[t].p[j]);
      send_frame(1'b1, 0);
      finish_frame($sformatf("tbl%0d", t), tbl[t].exp_y, tbl[t].exp_ovf, 0);
      accept(0);
      model_ovf = tbl[t].exp_ovf;
    end
    pulse_clr_ovf();

    // Backpressure: a pending beat must not be taken while the output waits.
    fq = '{20, -4};
    send_frame(1'b1, 0);
    finish_frame("hold", 2, 0, 0);
    prod_valid_i = 1'b1; prod_i = 8'sd127; prod_last_i = 1'b1;
    accept(5);
    prod_valid_i = 1'b0; prod_last_i = 1'b0;
    step();
    check("hold_no_stray_beat", int'(tap_cnt_o), 0);
    check("hold_no_stray_out", int'(y_valid_o), 0);

    // Frame forced to end at MAX_TAPS without last.
    fq = '{1, 2, 3, 4, 5, 6, 7, -4};
    send_frame(1'b0, 0);
    finish_frame("maxtaps", 3, 0, 1);
    accept(1);

    // Reset in the middle of a frame.
    fq = '{30, 30, 30};
    send_frame(1'b0, 0);
    check("mid_tap_cnt", int'(tap_cnt_o), 3);
    check("mid_no_out", int'(y_valid_o), 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("mrst_tap_cnt", int'(tap_cnt_o), 0);
    check("mrst_y", int'(y_o), 0);
    check("mrst_y_d1", int'(y_d1_o), 0);
    check("mrst_y_d2", int'(y_d2_o), 0);
    check("mrst_valid", int'(y_valid_o), 0);
    model_d1 = 0; model_d2 = 0; model_ovf = 0;
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    fq = '{8};
    send_frame(1'b1, 0);
    finish_frame("post_rst", 1, 0, 0);
    accept(0);

    // Random frames against the reference model.
    for (int f = 0; f < 60; f++) begin
      if (($urandom % 4) == 0) pulse_clr_ovf();
      len = $urandom_range(9, 1);
      wl  = (len <= int'(MAX_TAPS));
      if (!wl) len = MAX_TAPS;
      fq.delete();
      for (int j = 0; j < len; j++) fq.push_back(int'($signed(PROD_W'($urandom))));
      ey = model_frame(hit);
      if (hit != 0) model_ovf = 1;
      send_frame(wl, 2);
      finish_frame($sformatf("rnd%0d", f), ey, model_ovf, wl ? 0 : 1);
      accept($urandom_range(3, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
